aes_ctr_engine: RTL and testbench

AES_CTR_ENGINE -- requirements
Module: aes_ctr_engine

---
 rtl/aes_ctr_engine.sv | 268 ++++++++++++++++++++++++++
 tb/tb_aes_ctr_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: block-cipher job engine in front of an iterative AES-128 core.
//   MODE 0 = ECB (out = E(in)); MODE 1 = CTR (out = E(ctr) ^ in, with
//   ctr[CTR_W-1:0] stepping by one per block).
// Ports:
//   clk, rst              - rising-edge clock, asynchronous active-high reset
//   start, nblocks,
//   key, iv               - job request and its parameters (sampled with start)
//   in_valid/in_ready/
//   in_data               - input block stream
//   out_valid/out_ready/
//   out_data              - output block stream (OBUF_DEPTH-entry FIFO head)
//   busy, done, blk_cnt   - job status, end-of-job pulse, blocks delivered
// Also contains aes_cipher_top: an iterative AES-128 encryptor with
// active-low reset, one round per cycle; done is held high after a block
// finishes until the next ld.

module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);
  logic [127:0] st, rk, nk;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         run;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box computed as x^254 (multiplicative inverse, 0 -> 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y, inv;
    y   = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      y   = gmul(y, y);
      inv = gmul(inv, y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, tmp;
    {w0, w1, w2, w3} = k;
    tmp = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ tmp;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // State bytes are column-major: byte 4*c+r sits at bits [127-8*(4c+r) -: 8].
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rkey,
                                             input logic last);
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ rkey;
  endfunction

  assign nk       = next_key(rk, rcon);
  assign text_out = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= '0;
      rk   <= '0;
      rcon <= '0;
      rnd  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else if (ld) begin
      st   <= text_in ^ key;
      rk   <= key;
      rcon <= 8'h01;
      rnd  <= 4'd1;
      run  <= 1'b1;
      done <= 1'b0;
    end else if (run) begin
      st   <= aes_round(st, nk, rnd == 4'd10);
      rk   <= nk;
      rcon <= xt(rcon);
      rnd  <= rnd + 4'd1;
      if (rnd == 4'd10) begin
        run  <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

module aes_ctr_engine #(
  parameter int MODE       = 0,
  parameter int CTR_W      = 32,
  parameter int OBUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  nblocks,
  input  logic [127:0] key,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic         done,
  output logic [15:0]  blk_cnt
);
  localparam int PW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  // For CTR_W=128 the shift yields 0 and the subtraction wraps to all ones,
  // so the whole word takes part in the increment.
  localparam logic [127:0] CTR_MASK = (128'd1 << CTR_W) - 128'd1;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, PUSH, FIN} state_t;
  state_t state, state_next;

  logic [15:0]  left_q;
  logic [127:0] key_q, ctr_q, data_q;
  logic         core_ld, core_done, core_done_q, core_rise;
  logic [127:0] core_text_in, core_text_out, result;
  logic [127:0] mem [OBUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic         push, pop, full, empty, done_next;

  aes_cipher_top u_core (
    .clk      (clk),
    .rst      (~rst),
    .ld       (core_ld),
    .done     (core_done),
    .key      (key_q),
    .text_in  (core_text_in),
    .text_out (core_text_out)
  );

  assign core_text_in = (MODE == 1) ? ctr_q : data_q;
  assign result       = (MODE == 1) ? (core_text_out ^ data_q) : core_text_out;
  // The core's done is a level that stays high until the next ld; only its
  // rising edge marks a fresh result.
  assign core_rise    = core_done & ~core_done_q;

  assign empty     = (count == '0);
  assign full      = (count == CW'(OBUF_DEPTH));
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    core_ld    = 1'b0;
    push       = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE:  if (start) state_next = (nblocks == 16'd0) ? FIN : FETCH;
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_next = LOAD;
      end
      LOAD: begin
        core_ld    = 1'b1;
        state_next = WAIT;
      end
      WAIT:  if (core_rise) state_next = PUSH;
      PUSH: begin
        // A pop in the same cycle frees a slot even when the FIFO is full.
        if (!full || pop) begin
          push       = 1'b1;
          state_next = (left_q == 16'd1) ? FIN : FETCH;
        end
      end
      FIN: begin
        if (empty) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      left_q      <= '0;
      key_q       <= '0;
      ctr_q       <= '0;
      data_q      <= '0;
      core_done_q <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      blk_cnt     <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      core_done_q <= core_done;
      done        <= done_next;
      if (state == IDLE && start) begin
        left_q  <= nblocks;
        key_q   <= key;
        ctr_q   <= iv;
        blk_cnt <= '0;
      end else if (pop) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
      if (in_ready && in_valid) data_q <= in_data;
      if (push) begin
        left_q <= left_q - 16'd1;
        ctr_q  <= (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end
endmodule

// File: tb/tb_aes_ctr_engine.sv
// Directed bench for aes_ctr_engine: one ECB instance (index 0) and one CTR
// instance with CTR_W=32 (index 1), checked against FIPS-197 / SP800-38A vectors.
module tb_aes_ctr_engine;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        start = '0, in_valid = '0, out_ready = '0;
  logic [1:0][15:0]  nblocks = '0;
  logic [1:0][127:0] key = '0, iv = '0, in_data = '0;
  logic [1:0]        in_ready, out_valid, busy, done;
  logic [1:0][127:0] out_data;
  logic [1:0][15:0]  blk_cnt;

  int total = 0;
  int bad   = 0;
  int ld_cnt [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic [127:0] tin_q[$];
  logic [127:0] in_q[$];
  logic [127:0] exp_q[$];

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] NK       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] NIV      = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  always #5 clk = ~clk;

  aes_ctr_engine #(.MODE(0)) dut_ecb (
    .clk(clk), .rst(rst), .start(start[0]), .nblocks(nblocks[0]), .key(key[0]), .iv(iv[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .busy(busy[0]), .done(done[0]), .blk_cnt(blk_cnt[0])
  );

  aes_ctr_engine #(.MODE(1), .CTR_W(32)) dut_ctr (
    .clk(clk), .rst(rst), .start(start[1]), .nblocks(nblocks[1]), .key(key[1]), .iv(iv[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .busy(busy[1]), .done(done[1]), .blk_cnt(blk_cnt[1])
  );

  // Event monitors: core load strobes, CTR core inputs, done pulses.
  always @(posedge clk) begin
    if (dut_ecb.core_ld) ld_cnt[0] <= ld_cnt[0] + 1;
    if (dut_ctr.core_ld) begin
      ld_cnt[1] <= ld_cnt[1] + 1;
      tin_q.push_back(dut_ctr.core_text_in);
    end
    if (done[0]) done_cnt[0] <= done_cnt[0] + 1;
    if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Runs one job on instance s; in_q supplies data, exp_q (if non-empty) the
  // expected outputs. hold keeps start high and scrambles inputs while busy.
  // stall holds out_ready low for that many cycles.
  task automatic run_job(input int s, input int n, input logic [127:0] k,
                         input logic [127:0] v, input bit hold, input int stall);
    int tx, rx, cyc, ld0, dn0;
    bit got_done;
    tx = 0; rx = 0; cyc = 0; got_done = 0;
    ld0 = ld_cnt[s];
    dn0 = done_cnt[s];
    start[s] = 1'b1; nblocks[s] = n[15:0]; key[s] = k; iv[s] = v;
    @(posedge clk); #1;
    check_val($sformatf("busy_after_start[%0d]", s), busy[s], 1'b1);
    if (!hold) start[s] = 1'b0;
    else begin
      key[s] = ~k; iv[s] = ~v; nblocks[s] = 16'd7;
    end
    while (!got_done && cyc < 600) begin
      out_ready[s] = (cyc >= stall);
      if (stall > 0 && cyc == stall - 1) begin
        // Depth-2 FIFO full plus one finished block parked in PUSH.
        check_val("stall_ld_count", 128'(ld_cnt[s] - ld0), 128'd3);
        check_val("stall_out_valid", out_valid[s], 1'b1);
        check_val("stall_in_ready", in_ready[s], 1'b0);
      end
      if (out_valid[s] && out_ready[s]) begin
        $display("inst %0d block %0d data=%h", s, rx, out_data[s]);
        if (rx < exp_q.size())
          check_val($sformatf("data[%0d][%0d]", s, rx), out_data[s], exp_q[rx]);
        rx++;
      end
      in_valid[s] = (tx < n);
      in_data[s]  = (tx < n) ? in_q[tx] : 128'd0;
      if (in_ready[s] && tx < n) tx++;
      if (done[s]) begin
        got_done = 1;
        if (hold) start[s] = 1'b0;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    in_valid[s] = 1'b0;
    check_val($sformatf("done_seen[%0d]", s), got_done, 1'b1);
    check_val($sformatf("rx_count[%0d]", s), 128'(rx), 128'(n));
    check_val($sformatf("blk_cnt[%0d]", s), blk_cnt[s], n[15:0]);
    check_val($sformatf("ld_count[%0d]", s), 128'(ld_cnt[s] - ld0), 128'(n));
    if (n == 0) check_val("zero_done_latency", 128'(cyc), 128'd1);
    @(posedge clk); #1;
    check_val($sformatf("done_pulses[%0d]", s), 128'(done_cnt[s] - dn0), 128'd1);
    check_val($sformatf("done_low_after[%0d]", s), done[s], 1'b0);
    check_val($sformatf("busy_low_after[%0d]", s), busy[s], 1'b0);
    $display("inst %0d job n=%0d finished after %0d cycles", s, n, cyc);
  endtask

  initial begin
    int ld0, dn0, cyc;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check_val($sformatf("rst_out_valid[%0d]", s), out_valid[s], 1'b0);
      check_val($sformatf("rst_in_ready[%0d]", s), in_ready[s], 1'b0);
      check_val($sformatf("rst_busy[%0d]", s), busy[s], 1'b0);
      check_val($sformatf("rst_done[%0d]", s), done[s], 1'b0);
      check_val($sformatf("rst_blk_cnt[%0d]", s), blk_cnt[s], 16'd0);
    end
    rst = 1'b0;
    out_ready = 2'b11;

    // ECB, FIPS-197 single block, started in the first cycle after reset.
    in_q = {FIPS_PT}; exp_q = {FIPS_CT};
    run_job(0, 1, FIPS_KEY, 128'd0, 1'b0, 0);

    // ECB, empty job: done two cycles after start, no loads.
    in_q = {}; exp_q = {};
    run_job(0, 0, FIPS_KEY, 128'd0, 1'b0, 0);

    // ECB, back-pressure with 4 blocks through a depth-2 buffer.
    in_q  = {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    exp_q = {128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
             128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};
    run_job(0, 4, NK, 128'd0, 1'b0, 80);

    // ECB, start held high through the job with scrambled inputs while busy.
    in_q = {FIPS_PT}; exp_q = {FIPS_CT};
    run_job(0, 1, FIPS_KEY, 128'd0, 1'b1, 0);

    // CTR, SP800-38A vector, 4 blocks.
    in_q  = {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    exp_q = {128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
             128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};
    tin_q = {};
    run_job(1, 4, NK, NIV, 1'b0, 0);
    check_val("ctr_tin0", tin_q[0], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
    check_val("ctr_tin1", tin_q[1], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);
    check_val("ctr_tin3", tin_q[3], 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02);

    // CTR, low 32-bit field wraps; upper 96 bits stay put.
    in_q = {128'd0, 128'd1, 128'd2}; exp_q = {};
    tin_q = {};
    run_job(1, 3, NK, 128'h0123456789abcdef01234567_fffffffe, 1'b0, 0);
    check_val("wrap_tin0", tin_q[0], 128'h0123456789abcdef01234567_fffffffe);
    check_val("wrap_tin1", tin_q[1], 128'h0123456789abcdef01234567_ffffffff);
    check_val("wrap_tin2", tin_q[2], 128'h0123456789abcdef01234567_00000000);

    // CTR, reset during WAIT of block 2 with block 1 parked in the buffer.
    ld0 = ld_cnt[1];
    dn0 = done_cnt[1];
    out_ready[1] = 1'b0;
    start[1] = 1'b1; nblocks[1] = 16'd3; key[1] = NK; iv[1] = NIV;
    in_valid[1] = 1'b1; in_data[1] = 128'h6bc1bee22e409f96e93d7e117393172a;
    @(posedge clk); #1;
    start[1] = 1'b0;
    cyc = 0;
    while (ld_cnt[1] - ld0 < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("abort_reached_ld2", 128'(ld_cnt[1] - ld0), 128'd2);
    repeat (3) @(posedge clk);
    #1;
    check_val("abort_pre_out_valid", out_valid[1], 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", out_valid[1], 1'b0);
    check_val("abort_in_ready", in_ready[1], 1'b0);
    check_val("abort_busy", busy[1], 1'b0);
    check_val("abort_blk_cnt", blk_cnt[1], 16'd0);
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready[1] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_val("abort_no_done", 128'(done_cnt[1] - dn0), 128'd0);
    check_val("abort_out_empty", out_valid[1], 1'b0);

    // A fresh job after the reset completes correctly.
    in_q  = {128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    exp_q = {128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff};
    run_job(1, 2, NK, NIV, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
